vq_cb_vram_arbiter: RTL and testbench

- Sequences codebook-cache fills and shares the single VRAM read port between two requesters: the codebook fill engine and the texel fetch unit.
- A codebook fill (256 x 64-bit words) is split into fixed-length bursts.
- When a texel read is pending, one single-word texel read is interleaved between successive codebook bursts.
- Sits between the codebook cache, the texel fetch stage and the PVR VRAM read port.

---
 rtl/vq_cb_vram_arbiter.sv | 122 ++++++++++++
 tb/tb_vq_cb_vram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vq_cb_vram_arbiter.sv
// Shares the single VRAM read port between codebook-cache fills and texel fetches.
// A fill is issued as fixed-length bursts, and a pending texel read is slotted in between two bursts.
module vq_cb_vram_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int BURST_LEN = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cb_req,
  input  logic [ADDR_W-1:0] cb_base,
  input  logic [7:0]        cb_offset,
  output logic              cb_valid,
  input  logic              tex_req,
  input  logic [ADDR_W-1:0] tex_addr,
  output logic              tex_ack,
  output logic              tex_valid,
  output logic              vram_rd,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [8:0]        vram_burst,
  input  logic              vram_wait,
  input  logic              vram_valid
);

  typedef enum logic [2:0] {IDLE, CB_CMD, CB_DATA, TEX_CMD, TEX_DATA} state_e;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(7));

  state_e            state_q, state_d;
  logic              last_cb_q;
  logic              fill_q;
  logic              tex_ack_q;
  logic [8:0]        beat_cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] tex_addr_q;
  logic [ADDR_W-1:0] cb_addr;
  logic              accept;
  logic              last_beat;
  logic              enter_cb;
  logic              enter_tex;

  assign accept    = vram_rd && !vram_wait;
  assign last_beat = vram_valid && (beat_cnt_q == 9'(BURST_LEN - 1));
  assign cb_addr   = base_q + ADDR_W'({cb_offset, 3'b000});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cb_req && tex_req) state_d = last_cb_q ? TEX_CMD : CB_CMD;
        else if (cb_req)       state_d = CB_CMD;
        else if (tex_req)      state_d = TEX_CMD;
      end
      CB_CMD:  if (accept) state_d = CB_DATA;
      CB_DATA: begin
        if (last_beat) begin
          if (tex_req)     state_d = TEX_CMD;
          else if (cb_req) state_d = CB_CMD;
          else             state_d = IDLE;
        end
      end
      TEX_CMD:  if (accept) state_d = TEX_DATA;
      TEX_DATA: if (vram_valid) state_d = cb_req ? CB_CMD : IDLE;
      default:  state_d = IDLE;
    endcase
    enter_cb  = (state_d == CB_CMD)  && (state_q != CB_CMD);
    enter_tex = (state_d == TEX_CMD) && (state_q != TEX_CMD);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_cb_q  <= 1'b0;
      fill_q     <= 1'b0;
      tex_ack_q  <= 1'b0;
      beat_cnt_q <= '0;
      base_q     <= '0;
      tex_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      tex_ack_q <= enter_tex;
      if (enter_tex) tex_addr_q <= tex_addr & ALIGN_MASK;
      // The base is captured only at the start of a fill; any low cb_req ends that fill.
      if (enter_cb && !fill_q) base_q <= cb_base;
      fill_q <= cb_req && (fill_q || enter_cb);
      if (state_q == CB_CMD && accept)
        beat_cnt_q <= '0;
      else if (state_q == CB_DATA && vram_valid)
        beat_cnt_q <= beat_cnt_q + 9'd1;
      if (state_q == CB_DATA && last_beat)
        last_cb_q <= 1'b1;
      else if (state_q == TEX_DATA && vram_valid)
        last_cb_q <= 1'b0;
    end
  end

  always_comb begin
    vram_rd    = 1'b0;
    vram_addr  = '0;
    vram_burst = '0;
    case (state_q)
      CB_CMD: begin
        vram_rd    = 1'b1;
        vram_addr  = cb_addr;
        vram_burst = 9'(BURST_LEN);
      end
      TEX_CMD: begin
        vram_rd    = 1'b1;
        vram_addr  = tex_addr_q;
        vram_burst = 9'd1;
      end
      default: ;
    endcase
  end

  assign cb_valid  = (state_q == CB_DATA) && vram_valid && cb_req;
  assign tex_valid = (state_q == TEX_DATA) && vram_valid;
  assign tex_ack   = tex_ack_q;

  // Read data must never arrive while a command is still outstanding.
  assert property (@(posedge clock) disable iff (!reset_n) !(vram_valid && vram_rd));

endmodule

// File: tb/tb_vq_cb_vram_arbiter.sv
// Directed bench for vq_cb_vram_arbiter: fills, texel interleave, arbitration, stalls, reset and wrap.
module tb_vq_cb_vram_arbiter;

  logic        clock;
  logic        reset_n;
  logic        cb_req;
  logic [23:0] cb_base;
  logic [7:0]  cb_offset;
  logic        cb_valid;
  logic        tex_req;
  logic [23:0] tex_addr;
  logic        tex_ack;
  logic        tex_valid;
  logic        vram_rd;
  logic [23:0] vram_addr;
  logic [8:0]  vram_burst;
  logic        vram_wait;
  logic        vram_valid;

  int checks;
  int errors;
  int n_strobe;

  vq_cb_vram_arbiter #(.ADDR_W(24), .BURST_LEN(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cb_req     (cb_req),
    .cb_base    (cb_base),
    .cb_offset  (cb_offset),
    .cb_valid   (cb_valid),
    .tex_req    (tex_req),
    .tex_addr   (tex_addr),
    .tex_ack    (tex_ack),
    .tex_valid  (tex_valid),
    .vram_rd    (vram_rd),
    .vram_addr  (vram_addr),
    .vram_burst (vram_burst),
    .vram_wait  (vram_wait),
    .vram_valid (vram_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One codebook command (optionally stalled) followed by its 8 beats; the cache advances on cb_valid.
  task automatic cb_burst(input string tag, input logic [23:0] exp_addr, input int waits,
                          input int tex_at, input int stop_after);
    for (int w = 0; w <= waits; w++) begin
      @(negedge clock);
      vram_valid = 1'b0;
      vram_wait  = (w < waits);
      #1;
      chk($sformatf("%s_rd_w%0d", tag, w), vram_rd, 1);
      chk($sformatf("%s_addr_w%0d", tag, w), vram_addr, exp_addr);
      chk($sformatf("%s_burst_w%0d", tag, w), vram_burst, 8);
      chk($sformatf("%s_ack_w%0d", tag, w), tex_ack, 0);
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge clock);
      vram_valid = 1'b1;
      if (b == tex_at) tex_req = 1'b1;
      #1;
      if (cb_valid) begin
        n_strobe++;
        cb_offset = cb_offset + 8'd1;
        if (n_strobe == stop_after) cb_req = 1'b0;
      end
    end
  endtask

  task automatic tex_read(input string tag, input logic [23:0] exp_addr);
    @(negedge clock);
    vram_valid = 1'b0;
    #1;
    chk({tag, "_rd"}, vram_rd, 1);
    chk({tag, "_addr"}, vram_addr, exp_addr);
    chk({tag, "_burst"}, vram_burst, 1);
    chk({tag, "_ack"}, tex_ack, 1);
    tex_req = 1'b0;
    @(negedge clock);
    vram_valid = 1'b1;
    #1;
    chk({tag, "_ack_once"}, tex_ack, 0);
    chk({tag, "_valid"}, tex_valid, 1);
    chk({tag, "_no_cbv"}, cb_valid, 0);
    chk({tag, "_rd_low"}, vram_rd, 0);
  endtask

  initial begin
    checks = 0; errors = 0; n_strobe = 0;
    reset_n = 1'b0; cb_req = 1'b0; cb_base = '0; cb_offset = '0;
    tex_req = 1'b0; tex_addr = '0; vram_wait = 1'b0; vram_valid = 1'b0;

    // Reset state
    @(negedge clock); @(negedge clock);
    #1;
    chk("rst_rd", vram_rd, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_burst", vram_burst, 0);
    chk("rst_cbv", cb_valid, 0);
    chk("rst_texv", tex_valid, 0);
    chk("rst_ack", tex_ack, 0);

    // Full 256-word fill, no texel traffic
    @(negedge clock);
    reset_n = 1'b1; cb_base = 24'h100000; cb_offset = 8'd0; cb_req = 1'b1; n_strobe = 0;
    for (int k = 0; k < 32; k++)
      cb_burst("t1", 24'h100000 + 24'(k * 64), 0, -1, 256);
    @(negedge clock);
    vram_valid = 1'b0;
    #1;
    chk("t1_strobes", n_strobe, 256);
    chk("t1_idle_rd", vram_rd, 0);
    @(negedge clock);
    #1;
    chk("t1_idle_rd2", vram_rd, 0);

    // Texel read raised during the first burst is interleaved after it
    @(negedge clock);
    cb_base = 24'h300000; cb_offset = 8'd0; cb_req = 1'b1; tex_addr = 24'h200008; n_strobe = 0;
    cb_burst("t2a", 24'h300000, 0, 2, -1);
    tex_read("t2_tex", 24'h200008);
    cb_burst("t2b", 24'h300040, 0, -1, 16);
    @(negedge clock);
    vram_valid = 1'b0;
    #1;
    chk("t2_strobes", n_strobe, 16);
    chk("t2_idle_rd", vram_rd, 0);

    // Texel-only read from IDLE (low address bits dropped); leaves last_cb clear
    @(negedge clock);
    tex_req = 1'b1; tex_addr = 24'h12345F;
    tex_read("t3_pre", 24'h123458);

    // Simultaneous requests: codebook first (with a 5-cycle stall), then texel
    @(negedge clock);
    vram_valid = 1'b0;
    cb_req = 1'b1; tex_req = 1'b1; cb_base = 24'h400000; cb_offset = 8'd0;
    tex_addr = 24'h200010; n_strobe = 0;
    cb_burst("t3_cb", 24'h400000, 5, -1, -1);
    tex_read("t3_tex", 24'h200010);
    cb_burst("t3_cb2", 24'h400040, 0, -1, 16);
    @(negedge clock);
    vram_valid = 1'b0;
    #1;
    chk("t3_strobes", n_strobe, 16);
    chk("t3_idle_rd", vram_rd, 0);

    // Asynchronous reset during beat 3, then stray beats
    @(negedge clock);
    cb_req = 1'b1; cb_base = 24'h500000; cb_offset = 8'd0;
    @(negedge clock);
    #1;
    chk("t5_cmd_rd", vram_rd, 1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clock);
      vram_valid = 1'b1;
    end
    @(negedge clock);
    #1;
    chk("t5_beat3_cbv", cb_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_cbv", cb_valid, 0);
    chk("t5_rst_rd", vram_rd, 0);
    chk("t5_rst_addr", vram_addr, 0);
    chk("t5_rst_burst", vram_burst, 0);
    chk("t5_rst_texv", tex_valid, 0);
    chk("t5_rst_ack", tex_ack, 0);
    @(negedge clock);
    cb_req = 1'b0; tex_req = 1'b0; reset_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      vram_valid = 1'b1;
      #1;
      chk($sformatf("t5_stray_cbv%0d", s), cb_valid, 0);
      chk($sformatf("t5_stray_texv%0d", s), tex_valid, 0);
    end

    // Address wrap, and cb_req dropping mid-burst
    @(negedge clock);
    vram_valid = 1'b0;
    cb_base = 24'hFFFFC0; cb_offset = 8'd8; cb_req = 1'b1; n_strobe = 0;
    cb_burst("t6", 24'h000000, 0, -1, 4);
    @(negedge clock);
    vram_valid = 1'b0;
    #1;
    chk("t6_strobes", n_strobe, 4);
    chk("t6_offset", cb_offset, 12);
    chk("t6_idle_rd", vram_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
